// File: rtl/vl_equiv_monitor_if.sv
// Bundle of compare inputs and monitor results for vl_equiv_monitor.
// The bench drives through master; the monitor attaches as slave.
interface vl_equiv_monitor_if #(
   parameter int WIDTH = 8,
   parameter int NCHAN = 4,
   parameter int CNT_W = 16
);
   logic                     clear;
   logic                     check;
   logic [NCHAN-1:0]         chan_mask;
   logic [NCHAN*WIDTH-1:0]   spec_bus;
   logic [NCHAN*WIDTH-1:0]   impl_bus;
   logic [NCHAN-1:0]         mismatch;
   logic                     any_fail;
   logic [1:0]               state;
   logic [CNT_W-1:0]         check_count;
   logic [CNT_W-1:0]         fail_count;
   logic [$clog2(NCHAN):0]   first_chan;
   logic [WIDTH-1:0]         first_spec;
   logic [WIDTH-1:0]         first_impl;

   modport master (
      output clear, check, chan_mask, spec_bus, impl_bus,
      input  mismatch, any_fail, state, check_count, fail_count,
             first_chan, first_spec, first_impl
   );

   modport slave (
      input  clear, check, chan_mask, spec_bus, impl_bus,
      output mismatch, any_fail, state, check_count, fail_count,
             first_chan, first_spec, first_impl
   );
endinterface

// File: rtl/vl_equiv_monitor.sv
// Multi-channel 4-state spec-vs-impl equivalence monitor with counters and first-failure capture.
// Optional feature: define VL_CMP_XWILD_EN to treat unknown spec bits as wildcards.
module vl_equiv_monitor #(
   parameter int WIDTH  = 8,
   parameter int NCHAN  = 4,
   parameter int CNT_W  = 16,
   parameter int STICKY = 1
) (
   input logic               clk,
   input logic               rst,
   vl_equiv_monitor_if.slave bus
);
   localparam int CW = $clog2(NCHAN) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FAIL = 2'b10
   } state_t;

   function automatic logic [WIDTH-1:0] unknown_bits(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] u;
      for (int b = 0; b < WIDTH; b++) begin
         u[b] = (v[b] !== 1'b0) && (v[b] !== 1'b1);
      end
      return u;
   endfunction

   // z and x both collapse to x so captured values never carry z
   function automatic logic [WIDTH-1:0] norm(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] u;
      logic [WIDTH-1:0] n;
      u = unknown_bits(v);
      for (int b = 0; b < WIDTH; b++) begin
         n[b] = u[b] ? 1'bx : v[b];
      end
      return n;
   endfunction

   function automatic logic chan_diff(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] i);
      logic [WIDTH-1:0] su;
      logic [WIDTH-1:0] iu;
      logic             bit_ok;
      logic             diff;
      su   = unknown_bits(s);
      iu   = unknown_bits(i);
      diff = 1'b0;
      for (int b = 0; b < WIDTH; b++) begin
         if (su[b] && iu[b]) begin
            bit_ok = 1'b1;
         end else if (!su[b] && !iu[b]) begin
            bit_ok = (s[b] == i[b]);
         end else begin
            bit_ok = 1'b0;
         end
`ifdef VL_CMP_XWILD_EN
         bit_ok = bit_ok | su[b];
`endif
         diff = diff | ~bit_ok;
      end
      return diff;
   endfunction

   state_t             state_q, state_d;
   logic [NCHAN-1:0]   mismatch_q, mismatch_d;
   logic               any_fail_q, any_fail_d;
   logic [CNT_W-1:0]   check_count_q, check_count_d;
   logic [CNT_W-1:0]   fail_count_q, fail_count_d;
   logic               captured_q, captured_d;
   logic [CW-1:0]      first_chan_q, first_chan_d;
   logic [WIDTH-1:0]   first_spec_q, first_spec_d;
   logic [WIDTH-1:0]   first_impl_q, first_impl_d;

   logic [NCHAN-1:0]   mism_s;
   logic               fail_s;
   logic [CW-1:0]      first_idx_s;

   // Per-channel compare and lowest-index failing channel
   always_comb begin
      mism_s      = '0;
      first_idx_s = '0;
      for (int c = 0; c < NCHAN; c++) begin
         mism_s[c] = bus.chan_mask[c] &
                     chan_diff(bus.spec_bus[c*WIDTH +: WIDTH], bus.impl_bus[c*WIDTH +: WIDTH]);
      end
      for (int c = NCHAN - 1; c >= 0; c--) begin
         first_idx_s = mism_s[c] ? CW'(c) : first_idx_s;
      end
      fail_s = |mism_s;
   end

   // Next-state, counters and capture; clear beats check
   always_comb begin
      state_d       = state_q;
      mismatch_d    = '0;
      any_fail_d    = 1'b0;
      check_count_d = check_count_q;
      fail_count_d  = fail_count_q;
      captured_d    = captured_q;
      first_chan_d  = first_chan_q;
      first_spec_d  = first_spec_q;
      first_impl_d  = first_impl_q;
      if (bus.clear) begin
         state_d       = ST_IDLE;
         check_count_d = '0;
         fail_count_d  = '0;
         captured_d    = 1'b0;
         first_chan_d  = '0;
         first_spec_d  = '0;
         first_impl_d  = '0;
      end else if (bus.check) begin
         mismatch_d    = mism_s;
         any_fail_d    = fail_s;
         check_count_d = (check_count_q == CNT_MAX) ? CNT_MAX : check_count_q + CNT_ONE;
         if (fail_s) begin
            fail_count_d = (fail_count_q == CNT_MAX) ? CNT_MAX : fail_count_q + CNT_ONE;
         end else begin
            fail_count_d = fail_count_q;
         end
         if (fail_s && !captured_q) begin
            captured_d   = 1'b1;
            first_chan_d = first_idx_s;
            first_spec_d = norm(bus.spec_bus[first_idx_s*WIDTH +: WIDTH]);
            first_impl_d = norm(bus.impl_bus[first_idx_s*WIDTH +: WIDTH]);
         end else begin
            captured_d   = captured_q;
         end
         case (state_q)
            ST_IDLE, ST_RUN: state_d = fail_s ? ST_FAIL : ST_RUN;
            ST_FAIL:         state_d = (fail_s || (STICKY != 0)) ? ST_FAIL : ST_RUN;
            default:         state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         mismatch_q    <= '0;
         any_fail_q    <= 1'b0;
         check_count_q <= '0;
         fail_count_q  <= '0;
         captured_q    <= 1'b0;
         first_chan_q  <= '0;
         first_spec_q  <= '0;
         first_impl_q  <= '0;
      end else begin
         state_q       <= state_d;
         mismatch_q    <= mismatch_d;
         any_fail_q    <= any_fail_d;
         check_count_q <= check_count_d;
         fail_count_q  <= fail_count_d;
         captured_q    <= captured_d;
         first_chan_q  <= first_chan_d;
         first_spec_q  <= first_spec_d;
         first_impl_q  <= first_impl_d;
      end
   end

   assign bus.mismatch    = mismatch_q;
   assign bus.any_fail    = any_fail_q;
   assign bus.state       = state_q;
   assign bus.check_count = check_count_q;
   assign bus.fail_count  = fail_count_q;
   assign bus.first_chan  = first_chan_q;
   assign bus.first_spec  = first_spec_q;
   assign bus.first_impl  = first_impl_q;
endmodule
